// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - decode/issue/writeback port bundle for regfile_scoreboard
interface regfile_scoreboard_if;
  // decode-stage read ports
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [31:0] rs1_v;
  logic [31:0] rs2_v;
  logic        rs1_busy;
  logic        rs2_busy;

  // issue handshake
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_rd;
  logic        issue_ready;

  // writeback write port
  logic        regf_we;
  logic [4:0]  rd_s;
  logic [31:0] rd_v;

  // pipeline control and status
  logic        flush;
  logic        pend_any;

  // pipeline side: drives addresses, issue and writeback
  modport master (
    output rs1_s, rs2_s, issue_valid, issue_we, issue_rd,
    output regf_we, rd_s, rd_v, flush,
    input  rs1_v, rs2_v, rs1_busy, rs2_busy, issue_ready, pend_any
  );

  // register file side
  modport slave (
    input  rs1_s, rs2_s, issue_valid, issue_we, issue_rd,
    input  regf_we, rd_s, rd_v, flush,
    output rs1_v, rs2_v, rs1_busy, rs2_busy, issue_ready, pend_any
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - architectural register file with per-register pending-write scoreboard
module regfile_scoreboard #(
  parameter int PEND_W    = 3,
  parameter bit BYPASS_EN = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  // Entry 0 of both arrays is held at zero so x0 reads as 0 and is never busy.
  logic [31:0]       regs      [32];
  logic [PEND_W-1:0] pend      [32];
  logic [PEND_W-1:0] pend_next [32];
  logic              pend_any_q;
  logic              pend_any_next;

  logic              issue_ready;
  logic              issue_fire;
  logic              wb_fire;
  logic              inc_r;
  logic              dec_r;

  // Forwarding mux for one read port: x0, then same-cycle writeback, then array.
  function automatic logic [31:0] read_port(
    input logic [4:0]  addr,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic [31:0] stored
  );
    if (addr == 5'd0) begin
      return 32'd0;
    end
    if (BYPASS_EN && we && (wa == addr)) begin
      return wd;
    end
    return stored;
  endfunction

  // A source is busy while it has writers in flight, unless the last one
  // is writing back right now and its data is reaching decode via bypass.
  function automatic logic busy_port(
    input logic [4:0]        addr,
    input logic [PEND_W-1:0] cnt,
    input logic              we,
    input logic [4:0]        wa
  );
    logic resolved;
    resolved = BYPASS_EN && we && (wa == addr) && (cnt == PEND_ONE);
    return (addr != 5'd0) && (cnt != '0) && !resolved;
  endfunction

  // Saturation check only looks at the destination, never at issue_valid,
  // so decode can use it without forming a combinational loop.
  always_comb begin
    issue_ready = 1'b1;
    if (bus.issue_we && (bus.issue_rd != 5'd0) && (pend[bus.issue_rd] == PEND_MAX)) begin
      issue_ready = 1'b0;
    end
  end

  // Qualified issue and writeback events; flush drops the issue, not the writeback.
  always_comb begin
    issue_fire = bus.issue_valid && bus.issue_we && issue_ready && !bus.flush
                 && (bus.issue_rd != 5'd0);
    wb_fire    = bus.regf_we && (bus.rd_s != 5'd0);
  end

  // Next pending count per register: simultaneous inc and dec cancel,
  // decrement saturates at zero, flush clears everything.
  always_comb begin
    inc_r = 1'b0;
    dec_r = 1'b0;
    for (int r = 0; r < 32; r++) begin
      pend_next[r] = pend[r];
    end
    pend_next[0] = '0;
    if (bus.flush) begin
      for (int r = 0; r < 32; r++) begin
        pend_next[r] = '0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        inc_r = issue_fire && (bus.issue_rd == 5'(r));
        dec_r = bus.regf_we && (bus.rd_s == 5'(r)) && (pend[r] != '0);
        if (inc_r && !dec_r) begin
          pend_next[r] = pend[r] + PEND_ONE;
        end else if (dec_r && !inc_r) begin
          pend_next[r] = pend[r] - PEND_ONE;
        end
      end
    end
  end

  // OR-reduce of the post-update counters, registered as pend_any.
  always_comb begin
    pend_any_next = 1'b0;
    for (int r = 1; r < 32; r++) begin
      if (pend_next[r] != '0) begin
        pend_any_next = 1'b1;
      end
    end
  end

  // Scoreboard state; reset wins over issue, writeback and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        pend[r] <= '0;
      end
      pend_any_q <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        pend[r] <= pend_next[r];
      end
      pend_any_q <= pend_any_next;
    end
  end

  // Register array write port; x0 writes are discarded so regs[0] stays 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        regs[r] <= 32'd0;
      end
    end else if (wb_fire) begin
      regs[bus.rd_s] <= bus.rd_v;
    end
  end

  // Combinational read data and hazard status for both decode ports.
  always_comb begin
    bus.rs1_v    = read_port(bus.rs1_s, bus.regf_we, bus.rd_s, bus.rd_v, regs[bus.rs1_s]);
    bus.rs2_v    = read_port(bus.rs2_s, bus.regf_we, bus.rd_s, bus.rd_v, regs[bus.rs2_s]);
    bus.rs1_busy = busy_port(bus.rs1_s, pend[bus.rs1_s], bus.regf_we, bus.rd_s);
    bus.rs2_busy = busy_port(bus.rs2_s, pend[bus.rs2_s], bus.regf_we, bus.rd_s);
  end

  assign bus.issue_ready = issue_ready;
  assign bus.pend_any    = pend_any_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_scoreboard_if bus ();

  regfile_scoreboard #(
    .PEND_W    (3),
    .BYPASS_EN (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.rs1_s       = 5'd0;
    bus.rs2_s       = 5'd0;
    bus.issue_valid = 1'b0;
    bus.issue_we    = 1'b0;
    bus.issue_rd    = 5'd0;
    bus.regf_we     = 1'b0;
    bus.rd_s        = 5'd0;
    bus.rd_v        = 32'd0;
    bus.flush       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_to(input logic [4:0] rd);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_rd    = rd;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.regf_we     = 1'b1;
    bus.rd_s        = 5'd5;
    bus.rd_v        = 32'h0000_DEAD;
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_rd    = 5'd5;
    tick();
    tick();
    rst = 1'b0;
    idle();
    bus.rs1_s    = 5'd5;
    bus.issue_we = 1'b1;
    bus.issue_rd = 5'd5;
    #1;
    n_checks++;
    if (bus.rs1_v !== 32'd0) begin
      n_fail++; $display("FAIL reset_rs1_v: got %h expected %h", bus.rs1_v, 32'd0);
    end
    n_checks++;
    if (bus.rs1_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_rs1_busy: got %b expected 0", bus.rs1_busy);
    end
    n_checks++;
    if (bus.pend_any !== 1'b0) begin
      n_fail++; $display("FAIL reset_pend_any: got %b expected 0", bus.pend_any);
    end
    n_checks++;
    if (bus.issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_issue_ready: got %b expected 1", bus.issue_ready);
    end
  endtask

  task automatic test_write_bypass();
    idle();
    bus.regf_we = 1'b1;
    bus.rd_s    = 5'd7;
    bus.rd_v    = 32'h1234_5678;
    bus.rs1_s   = 5'd7;
    #1;
    n_checks++;
    if (bus.rs1_v !== 32'h1234_5678) begin
      n_fail++; $display("FAIL bypass_rs1_v: got %h expected %h", bus.rs1_v, 32'h1234_5678);
    end
    tick();
    idle();
    bus.rs2_s = 5'd7;
    #1;
    n_checks++;
    if (bus.rs2_v !== 32'h1234_5678) begin
      n_fail++; $display("FAIL stored_rs2_v: got %h expected %h", bus.rs2_v, 32'h1234_5678);
    end
    bus.regf_we = 1'b1;
    bus.rd_s    = 5'd0;
    bus.rd_v    = 32'hFFFF_FFFF;
    bus.rs1_s   = 5'd0;
    #1;
    n_checks++;
    if (bus.rs1_v !== 32'd0) begin
      n_fail++; $display("FAIL x0_bypass: got %h expected %h", bus.rs1_v, 32'd0);
    end
    tick();
    idle();
    bus.rs1_s = 5'd0;
    #1;
    n_checks++;
    if (bus.rs1_v !== 32'd0) begin
      n_fail++; $display("FAIL x0_stored: got %h expected %h", bus.rs1_v, 32'd0);
    end
    n_checks++;
    if (bus.pend_any !== 1'b0) begin
      n_fail++; $display("FAIL write_pend_any: got %b expected 0", bus.pend_any);
    end
  endtask

  task automatic test_raw();
    issue_to(5'd0);
    idle();
    #1;
    n_checks++;
    if (bus.pend_any !== 1'b0 || bus.rs1_busy !== 1'b0) begin
      n_fail++; $display("FAIL x0_issue: got pend_any=%b busy=%b expected 0 0", bus.pend_any, bus.rs1_busy);
    end
    issue_to(5'd3);
    idle();
    bus.rs1_s = 5'd3;
    #1;
    n_checks++;
    if (bus.rs1_busy !== 1'b1) begin
      n_fail++; $display("FAIL raw_busy: got %b expected 1", bus.rs1_busy);
    end
    n_checks++;
    if (bus.pend_any !== 1'b1) begin
      n_fail++; $display("FAIL raw_pend_any: got %b expected 1", bus.pend_any);
    end
    bus.regf_we = 1'b1;
    bus.rd_s    = 5'd3;
    bus.rd_v    = 32'hCAFE_0003;
    #1;
    n_checks++;
    if (bus.rs1_busy !== 1'b0) begin
      n_fail++; $display("FAIL raw_resolved_busy: got %b expected 0", bus.rs1_busy);
    end
    n_checks++;
    if (bus.rs1_v !== 32'hCAFE_0003) begin
      n_fail++; $display("FAIL raw_resolved_v: got %h expected %h", bus.rs1_v, 32'hCAFE_0003);
    end
    tick();
    idle();
    bus.rs1_s = 5'd3;
    #1;
    n_checks++;
    if (bus.rs1_busy !== 1'b0 || bus.pend_any !== 1'b0) begin
      n_fail++; $display("FAIL raw_after: got busy=%b pend_any=%b expected 0 0", bus.rs1_busy, bus.pend_any);
    end
    n_checks++;
    if (bus.rs1_v !== 32'hCAFE_0003) begin
      n_fail++; $display("FAIL raw_after_v: got %h expected %h", bus.rs1_v, 32'hCAFE_0003);
    end
  endtask

  task automatic test_multi_writer();
    issue_to(5'd4);
    issue_to(5'd4);
    idle();
    bus.rs1_s   = 5'd4;
    bus.regf_we = 1'b1;
    bus.rd_s    = 5'd4;
    bus.rd_v    = 32'h0000_0044;
    #1;
    n_checks++;
    if (bus.rs1_busy !== 1'b1) begin
      n_fail++; $display("FAIL multi_first_wb_busy: got %b expected 1", bus.rs1_busy);
    end
    tick();
    idle();
    bus.rs1_s       = 5'd4;
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_rd    = 5'd4;
    bus.regf_we     = 1'b1;
    bus.rd_s        = 5'd4;
    bus.rd_v        = 32'h0000_0045;
    #1;
    n_checks++;
    if (bus.rs1_busy !== 1'b0) begin
      n_fail++; $display("FAIL multi_last_wb_busy: got %b expected 0", bus.rs1_busy);
    end
    tick();
    idle();
    bus.rs1_s = 5'd4;
    #1;
    n_checks++;
    if (bus.rs1_busy !== 1'b1 || bus.pend_any !== 1'b1) begin
      n_fail++; $display("FAIL multi_inc_dec: got busy=%b pend_any=%b expected 1 1", bus.rs1_busy, bus.pend_any);
    end
    bus.regf_we = 1'b1;
    bus.rd_s    = 5'd4;
    bus.rd_v    = 32'h0000_0046;
    tick();
    idle();
    bus.rs1_s = 5'd4;
    #1;
    n_checks++;
    if (bus.rs1_busy !== 1'b0 || bus.pend_any !== 1'b0) begin
      n_fail++; $display("FAIL multi_drained: got busy=%b pend_any=%b expected 0 0", bus.rs1_busy, bus.pend_any);
    end
    n_checks++;
    if (bus.rs1_v !== 32'h0000_0046) begin
      n_fail++; $display("FAIL multi_value: got %h expected %h", bus.rs1_v, 32'h0000_0046);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 7; i++) begin
      idle();
      bus.issue_we = 1'b1;
      bus.issue_rd = 5'd9;
      #1;
      n_checks++;
      if (bus.issue_ready !== 1'b1) begin
        n_fail++; $display("FAIL sat_ready_%0d: got %b expected 1", i, bus.issue_ready);
      end
      issue_to(5'd9);
    end
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_rd    = 5'd9;
    #1;
    n_checks++;
    if (bus.issue_ready !== 1'b0) begin
      n_fail++; $display("FAIL sat_full: got %b expected 0", bus.issue_ready);
    end
    tick();
    idle();
    bus.issue_we = 1'b1;
    bus.issue_rd = 5'd9;
    #1;
    n_checks++;
    if (bus.issue_ready !== 1'b0) begin
      n_fail++; $display("FAIL sat_hold: got %b expected 0", bus.issue_ready);
    end
    bus.issue_rd = 5'd10;
    #1;
    n_checks++;
    if (bus.issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL sat_other_rd: got %b expected 1", bus.issue_ready);
    end
    bus.issue_we = 1'b0;
    bus.issue_rd = 5'd9;
    #1;
    n_checks++;
    if (bus.issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL sat_no_we: got %b expected 1", bus.issue_ready);
    end
    idle();
    bus.regf_we = 1'b1;
    bus.rd_s    = 5'd9;
    bus.rd_v    = 32'h0000_0009;
    tick();
    idle();
    bus.issue_we = 1'b1;
    bus.issue_rd = 5'd9;
    bus.rs1_s    = 5'd9;
    #1;
    n_checks++;
    if (bus.issue_ready !== 1'b1 || bus.rs1_busy !== 1'b1) begin
      n_fail++; $display("FAIL sat_after_wb: got ready=%b busy=%b expected 1 1", bus.issue_ready, bus.rs1_busy);
    end
    idle();
    bus.flush = 1'b1;
    tick();
    idle();
    #1;
    n_checks++;
    if (bus.pend_any !== 1'b0) begin
      n_fail++; $display("FAIL sat_flush: got %b expected 0", bus.pend_any);
    end
  endtask

  task automatic test_flush();
    issue_to(5'd2);
    issue_to(5'd2);
    idle();
    bus.flush       = 1'b1;
    bus.regf_we     = 1'b1;
    bus.rd_s        = 5'd2;
    bus.rd_v        = 32'h0000_00AB;
    bus.issue_valid = 1'b1;
    bus.issue_we    = 1'b1;
    bus.issue_rd    = 5'd6;
    tick();
    idle();
    bus.rs1_s = 5'd2;
    bus.rs2_s = 5'd6;
    #1;
    n_checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_busy: got rs1=%b rs2=%b expected 0 0", bus.rs1_busy, bus.rs2_busy);
    end
    n_checks++;
    if (bus.rs1_v !== 32'h0000_00AB) begin
      n_fail++; $display("FAIL flush_wb_data: got %h expected %h", bus.rs1_v, 32'h0000_00AB);
    end
    n_checks++;
    if (bus.pend_any !== 1'b0) begin
      n_fail++; $display("FAIL flush_pend_any: got %b expected 0", bus.pend_any);
    end
    bus.regf_we = 1'b1;
    bus.rd_s    = 5'd2;
    bus.rd_v    = 32'h0000_00CD;
    tick();
    idle();
    bus.rs1_s    = 5'd2;
    bus.issue_we = 1'b1;
    bus.issue_rd = 5'd2;
    #1;
    n_checks++;
    if (bus.rs1_v !== 32'h0000_00CD) begin
      n_fail++; $display("FAIL underflow_data: got %h expected %h", bus.rs1_v, 32'h0000_00CD);
    end
    n_checks++;
    if (bus.pend_any !== 1'b0 || bus.issue_ready !== 1'b1 || bus.rs1_busy !== 1'b0) begin
      n_fail++; $display("FAIL underflow_count: got pend_any=%b ready=%b busy=%b expected 0 1 0",
                         bus.pend_any, bus.issue_ready, bus.rs1_busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_write_bypass();
    test_raw();
    test_multi_writer();
    test_saturation();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
